// File: rtl/column_drop_engine_if.sv
// Move-request handshake between the game FSM (master) and the column drop engine (slave).
interface column_drop_engine_if #(
  parameter int COLS = 4
);
  logic            in_valid;
  logic [COLS-1:0] in_column;
  logic            in_ready;

  modport master (output in_valid, output in_column, input in_ready);
  modport slave  (input in_valid, input in_column, output in_ready);
endinterface

// File: rtl/column_drop_engine.sv
// Connect-4 board holder: accepts a one-hot column request, animates the piece falling
// one row per clock, then commits the cell and its owner and hands the turn over.
module column_drop_engine #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      game_active,
  column_drop_engine_if.slave       req,
  output logic                      busy,
  output logic [ROWS*COLS-1:0]      out_gameboard,
  output logic [ROWS*COLS-1:0]      out_players_cells,
  output logic                      fall_valid,
  output logic [$clog2(ROWS)-1:0]   fall_row,
  output logic [$clog2(COLS)-1:0]   fall_col,
  output logic                      invalid_column,
  output logic                      move_done,
  output logic                      next_player,
  output logic                      board_full
);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int N   = ROWS * COLS;
  localparam int TOP = (ROWS - 1) * COLS;

  typedef enum logic {IDLE, FALL} state_t;

  state_t        state, state_next;
  logic [N-1:0]  board_next, owner_next;
  logic          player_next;
  logic [RW-1:0] row_next;
  logic [CW-1:0] col_next;
  logic          invalid_next, done_next;

  logic          one_hot, top_taken, below_taken;
  logic [CW-1:0] req_col;

  assign req.in_ready = (state == IDLE);
  assign busy         = (state == FALL);
  assign fall_valid   = (state == FALL);
  assign board_full   = &out_gameboard[N-1:TOP];

  // x & (x-1) clears the lowest set bit, so a nonzero result means more than one bit.
  assign one_hot = (req.in_column != '0) &&
                   ((req.in_column & (req.in_column - 1'b1)) == '0);

  always_comb begin
    req_col   = '0;
    top_taken = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (req.in_column[c]) begin
        req_col   = CW'(c);
        top_taken = top_taken | out_gameboard[TOP + c];
      end
    end
  end

  always_comb begin
    below_taken = 1'b0;
    for (int r = 1; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (fall_row == RW'(r) && fall_col == CW'(c))
          below_taken = out_gameboard[(r - 1) * COLS + c];
  end

  // Landing commits cell, owner, turn toggle and the done pulse on one edge.
  always_comb begin
    state_next   = state;
    board_next   = out_gameboard;
    owner_next   = out_players_cells;
    player_next  = next_player;
    row_next     = fall_row;
    col_next     = fall_col;
    invalid_next = 1'b0;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (req.in_valid && game_active) begin
          if (!one_hot || top_taken) begin
            invalid_next = 1'b1;
          end else begin
            state_next = FALL;
            row_next   = RW'(ROWS - 1);
            col_next   = req_col;
          end
        end
      end
      FALL: begin
        if (fall_row != '0 && !below_taken) begin
          row_next = fall_row - 1'b1;
        end else begin
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              if (fall_row == RW'(r) && fall_col == CW'(c)) begin
                board_next[r * COLS + c] = 1'b1;
                owner_next[r * COLS + c] = next_player;
              end
            end
          end
          player_next = ~next_player;
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state             <= IDLE;
      out_gameboard     <= '0;
      out_players_cells <= '0;
      next_player       <= 1'b0;
      fall_row          <= '0;
      fall_col          <= '0;
      invalid_column    <= 1'b0;
      move_done         <= 1'b0;
    end else begin
      state             <= state_next;
      out_gameboard     <= board_next;
      out_players_cells <= owner_next;
      next_player       <= player_next;
      fall_row          <= row_next;
      fall_col          <= col_next;
      invalid_column    <= invalid_next;
      move_done         <= done_next;
    end
  end
endmodule
